// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RV64I multicycle sequencer.
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLT = 3'b010;
   localparam logic [2:0] F3_DW  = 3'b011;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;

   typedef logic [3:0] alu_cc_t;
   localparam alu_cc_t ALU_AND = 4'b0000;
   localparam alu_cc_t ALU_OR  = 4'b0001;
   localparam alu_cc_t ALU_ADD = 4'b0010;
   localparam alu_cc_t ALU_XOR = 4'b0011;
   localparam alu_cc_t ALU_SUB = 4'b0110;
   localparam alu_cc_t ALU_SLT = 4'b0111;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_ILLEGAL = 2'b01,
      ERR_MEM_TMO = 2'b10
   } err_t;

   // {supported, alu code} for the arithmetic funct3 field shared by R- and I-type
   function automatic logic [4:0] f3_to_alu(input logic [2:0] f3);
      case (f3)
         F3_ADD:  f3_to_alu = {1'b1, ALU_ADD};
         F3_SLT:  f3_to_alu = {1'b1, ALU_SLT};
         F3_XOR:  f3_to_alu = {1'b1, ALU_XOR};
         F3_OR:   f3_to_alu = {1'b1, ALU_OR};
         F3_AND:  f3_to_alu = {1'b1, ALU_AND};
         default: f3_to_alu = {1'b0, ALU_ADD};
      endcase
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction/ack in, control strobes and status out.
interface multicycle_controller_if #(
   parameter int INS_W    = 32,
   parameter int ALU_CC_W = 4,
   parameter int CNT_W    = 32
);
   logic [INS_W-1:0]    instruction;
   logic                mem_ack;
   logic                pc_en;
   logic                RegWrite;
   logic                MemtoReg;
   logic                ALUsrc;
   logic                MemRead;
   logic                MemWrite;
   logic [ALU_CC_W-1:0] ALU_CC;
   logic                halted;
   logic [1:0]          err_code;
   logic [CNT_W-1:0]    retired;

   modport master (
      input  instruction, mem_ack,
      output pc_en, RegWrite, MemtoReg, ALUsrc, MemRead, MemWrite, ALU_CC,
             halted, err_code, retired
   );

   modport slave (
      output instruction, mem_ack,
      input  pc_en, RegWrite, MemtoReg, ALUsrc, MemRead, MemWrite, ALU_CC,
             halted, err_code, retired
   );
endinterface

// File: rtl/ctrl_decoder.sv
// Combinational instruction decode from the latched IR.
module ctrl_decoder
   import ctrl_pkg::*;
#(
   parameter int INS_W    = 32,
   parameter int ALU_CC_W = 4
) (
   input  logic [INS_W-1:0]    ir,
   output logic                legal,
   output logic                is_ld,
   output logic                is_sd,
   output logic                is_imm,
   output logic [ALU_CC_W-1:0] alu_cc
);
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_b5;
   logic [4:0] f3_dec;
   logic       unused_ir;

   assign opcode    = ir[6:0];
   assign funct3    = ir[14:12];
   assign funct7_b5 = ir[30];
   assign f3_dec    = f3_to_alu(funct3);
   assign unused_ir = ^{ir[INS_W-1:31], ir[29:15], ir[11:7]};

   // is_imm means operand B comes from the immediate, so loads and stores set it too
   always_comb begin
      legal  = 1'b0;
      is_ld  = 1'b0;
      is_sd  = 1'b0;
      is_imm = 1'b0;
      alu_cc = ALU_CC_W'(ALU_ADD);
      case (opcode)
         OP_RTYPE: begin
            legal  = f3_dec[4];
            alu_cc = (funct3 == F3_ADD && funct7_b5) ? ALU_CC_W'(ALU_SUB)
                                                      : ALU_CC_W'(f3_dec[3:0]);
         end
         OP_ITYPE: begin
            legal  = f3_dec[4];
            is_imm = 1'b1;
            alu_cc = ALU_CC_W'(f3_dec[3:0]);
         end
         OP_LOAD: begin
            legal  = (funct3 == F3_DW);
            is_ld  = 1'b1;
            is_imm = 1'b1;
         end
         OP_STORE: begin
            legal  = (funct3 == F3_DW);
            is_sd  = 1'b1;
            is_imm = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the RV64I datapath strobes.
//  state  | meaning
//  FETCH  | latch instruction into IR
//  DECODE | check opcode/funct3, halt on illegal
//  EXEC   | ALU operates on decoded operands
//  MEM    | LD/SD access, wait for mem_ack or time out
//  WB     | regfile write, advance PC, retire
//  HALT   | stopped until reset
module multicycle_controller
   import ctrl_pkg::*;
#(
   parameter int INS_W    = 32,
   parameter int ALU_CC_W = 4,
   parameter int CNT_W    = 32,
   parameter int MEM_TMO  = 15,
   parameter int TMO_W    = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   multicycle_controller_if.master bus
);
   state_t              state, state_nxt;
   logic [INS_W-1:0]    ir;
   logic [TMO_W-1:0]    tmo, tmo_nxt;
   logic [CNT_W-1:0]    retired;
   err_t                err_q, err_nxt;
   logic                set_err;
   logic                retire;

   logic                dec_legal, dec_ld, dec_sd, dec_imm;
   logic [ALU_CC_W-1:0] dec_cc;

   logic                pc_en, reg_write, mem_to_reg, alu_src, mem_read, mem_write;
   logic [ALU_CC_W-1:0] alu_cc;

   ctrl_decoder #(
      .INS_W    (INS_W),
      .ALU_CC_W (ALU_CC_W)
   ) u_dec (
      .ir     (ir),
      .legal  (dec_legal),
      .is_ld  (dec_ld),
      .is_sd  (dec_sd),
      .is_imm (dec_imm),
      .alu_cc (dec_cc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_FETCH;
         ir      <= '0;
         tmo     <= '0;
         retired <= '0;
         err_q   <= ERR_NONE;
      end else begin
         state   <= state_nxt;
         tmo     <= tmo_nxt;
         retired <= retired + CNT_W'(retire);
         if (state == ST_FETCH) ir <= bus.instruction;
         if (set_err) err_q <= err_nxt;
      end
   end

   // tmo_nxt defaults to 0 so the timeout counter clears whenever MEM is left
   always_comb begin
      state_nxt  = state;
      tmo_nxt    = '0;
      set_err    = 1'b0;
      err_nxt    = ERR_NONE;
      retire     = 1'b0;
      pc_en      = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_cc     = '0;
      case (state)
         ST_FETCH: state_nxt = ST_DECODE;
         ST_DECODE: begin
            if (dec_legal) begin
               state_nxt = ST_EXEC;
            end else begin
               state_nxt = ST_HALT;
               set_err   = 1'b1;
               err_nxt   = ERR_ILLEGAL;
            end
         end
         ST_EXEC: begin
            alu_cc    = dec_cc;
            alu_src   = dec_imm;
            state_nxt = (dec_ld || dec_sd) ? ST_MEM : ST_WB;
         end
         ST_MEM: begin
            alu_cc    = ALU_CC_W'(ALU_ADD);
            alu_src   = 1'b1;
            mem_read  = dec_ld;
            mem_write = dec_sd;
            if (bus.mem_ack) begin
               if (dec_sd) begin
                  pc_en     = 1'b1;
                  retire    = 1'b1;
                  state_nxt = ST_FETCH;
               end else begin
                  state_nxt = ST_WB;
               end
            end else if (tmo == TMO_W'(MEM_TMO - 1)) begin
               state_nxt = ST_HALT;
               set_err   = 1'b1;
               err_nxt   = ERR_MEM_TMO;
            end else begin
               tmo_nxt = tmo + 1'b1;
            end
         end
         ST_WB: begin
            alu_cc     = dec_cc;
            alu_src    = dec_imm;
            reg_write  = 1'b1;
            mem_to_reg = !dec_ld;
            pc_en      = 1'b1;
            retire     = 1'b1;
            state_nxt  = ST_FETCH;
         end
         ST_HALT: ;
         default: state_nxt = ST_FETCH;
      endcase
   end

   assign bus.pc_en    = pc_en;
   assign bus.RegWrite = reg_write;
   assign bus.MemtoReg = mem_to_reg;
   assign bus.ALUsrc   = alu_src;
   assign bus.MemRead  = mem_read;
   assign bus.MemWrite = mem_write;
   assign bus.ALU_CC   = alu_cc;
   assign bus.halted   = (state == ST_HALT);
   assign bus.err_code = err_q;
   assign bus.retired  = retired;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: small program model, memory ack model, retire scoreboard.
module tb_multicycle_controller;
   localparam int MEM_TMO = 15;
   localparam int K_ALU = 0, K_LD = 1, K_SD = 2, K_ILL = 3;

   typedef struct {
      logic [31:0] ins;
      int          kind;
      logic [3:0]  cc;
      logic        src;
      int          k;
   } vec_t;

   typedef struct {
      int         cyc;
      logic       rw;
      logic       m2r;
      logic       src;
      logic [3:0] cc;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   multicycle_controller_if #(.INS_W(32), .ALU_CC_W(4), .CNT_W(32)) bus ();

   multicycle_controller #(
      .INS_W(32), .ALU_CC_W(4), .CNT_W(32), .MEM_TMO(MEM_TMO), .TMO_W(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t sb[$];
   vec_t prog[8];
   int   plen;
   vec_t tbl[22];
   vec_t v_zero;
   int   total = 0;
   int   bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run(input string tag, input int ncyc, input bit final_chk);
      int f, halt_cyc, exp_ret, exp_rd, exp_wr, exp_rw;
      int pc, mcnt, n_rd, n_wr, n_rw, hmis;
      logic [1:0] exp_err;
      logic exp_h, seen_pc_en;
      exp_t e, got;

      sb.delete();
      f = 1; halt_cyc = 1 << 30; exp_err = 2'b00;
      exp_ret = 0; exp_rd = 0; exp_wr = 0; exp_rw = 0;
      for (int i = 0; i < plen; i++) begin
         if (prog[i].kind == K_ILL) begin
            halt_cyc = f + 2; exp_err = 2'b01;
            break;
         end
         if (prog[i].kind != K_ALU && prog[i].k == 0) begin
            halt_cyc = f + 3 + MEM_TMO; exp_err = 2'b10;
            if (prog[i].kind == K_LD) exp_rd += MEM_TMO; else exp_wr += MEM_TMO;
            break;
         end
         e.src = prog[i].src; e.cc = prog[i].cc;
         if (prog[i].kind == K_ALU) begin
            e.cyc = f + 3; e.rw = 1'b1; e.m2r = 1'b1;
         end else if (prog[i].kind == K_LD) begin
            e.cyc = f + 3 + prog[i].k; e.rw = 1'b1; e.m2r = 1'b0; exp_rd += prog[i].k;
         end else begin
            e.cyc = f + 2 + prog[i].k; e.rw = 1'b0; e.m2r = 1'b0; exp_wr += prog[i].k;
         end
         exp_ret++;
         if (e.rw) exp_rw++;
         sb.push_back(e);
         f = e.cyc + 1;
      end

      reset = 1'b1; bus.mem_ack = 1'b0; bus.instruction = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      pc = 0; mcnt = 0; n_rd = 0; n_wr = 0; n_rw = 0; hmis = 0;

      for (int c = 1; c <= ncyc; c++) begin
         bus.instruction = (pc < plen) ? prog[pc].ins : 32'h0;
         if (bus.MemRead || bus.MemWrite) mcnt++; else mcnt = 0;
         if (mcnt != 0) bus.mem_ack = (pc < plen) && (mcnt == prog[pc].k);
         else           bus.mem_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (c == 1) begin
            check({tag, "_reset_retired"}, bus.retired, 0);
            check({tag, "_reset_err"}, bus.err_code, 0);
         end
         if (bus.pc_en) begin
            if (sb.size() == 0) begin
               check({tag, "_unexpected_pc_en"}, bus.pc_en, 0);
            end else begin
               got = sb.pop_front();
               check({tag, "_retire_cycle"}, c, got.cyc);
               check({tag, "_retire_strobes"}, {bus.RegWrite, bus.ALUsrc, bus.ALU_CC},
                     {got.rw, got.src, got.cc});
               if (got.rw) check({tag, "_memtoreg"}, bus.MemtoReg, got.m2r);
            end
         end
         if (bus.MemRead)  n_rd++;
         if (bus.MemWrite) n_wr++;
         if (bus.RegWrite) n_rw++;
         exp_h = (c >= halt_cyc);
         if (bus.halted !== exp_h) hmis++;
         if (exp_h && ({bus.pc_en, bus.RegWrite, bus.MemtoReg, bus.ALUsrc,
                        bus.MemRead, bus.MemWrite, bus.ALU_CC} != '0)) hmis++;
         seen_pc_en = bus.pc_en;
         @(posedge clk);
         #1;
         if (seen_pc_en) pc++;
      end

      check({tag, "_halt_track"}, hmis, 0);
      if (final_chk) begin
         check({tag, "_retired"}, bus.retired, exp_ret);
         check({tag, "_err_code"}, bus.err_code, exp_err);
         check({tag, "_memread_cycles"}, n_rd, exp_rd);
         check({tag, "_memwrite_cycles"}, n_wr, exp_wr);
         check({tag, "_regwrite_cycles"}, n_rw, exp_rw);
         check({tag, "_pending_retires"}, sb.size(), 0);
      end
   endtask

   initial begin
      v_zero = '{32'h0000_0000, K_ILL, 4'h0, 1'b0, 0};
      tbl = '{
         '{32'h002081B3, K_ALU, 4'b0010, 1'b0, 0},  // add
         '{32'h402081B3, K_ALU, 4'b0110, 1'b0, 0},  // sub
         '{32'h0020F1B3, K_ALU, 4'b0000, 1'b0, 0},  // and
         '{32'h0020E1B3, K_ALU, 4'b0001, 1'b0, 0},  // or
         '{32'h0020C1B3, K_ALU, 4'b0011, 1'b0, 0},  // xor
         '{32'h0020A1B3, K_ALU, 4'b0111, 1'b0, 0},  // slt
         '{32'h4020C1B3, K_ALU, 4'b0011, 1'b0, 0},  // xor with funct7[5] set
         '{32'h00508193, K_ALU, 4'b0010, 1'b1, 0},  // addi
         '{32'h0050F193, K_ALU, 4'b0000, 1'b1, 0},  // andi
         '{32'h0050E193, K_ALU, 4'b0001, 1'b1, 0},  // ori
         '{32'h0050C193, K_ALU, 4'b0011, 1'b1, 0},  // xori
         '{32'h0050A193, K_ALU, 4'b0111, 1'b1, 0},  // slti
         '{32'h40008193, K_ALU, 4'b0010, 1'b1, 0},  // addi, imm bit 30 set
         '{32'h0080B283, K_LD,  4'b0010, 1'b1, 3},  // ld, ack after 3
         '{32'h0080B283, K_LD,  4'b0010, 1'b1, 1},  // ld, immediate ack
         '{32'h0020B823, K_SD,  4'b0010, 1'b1, 1},  // sd, immediate ack
         '{32'h0020B823, K_SD,  4'b0010, 1'b1, 4},  // sd, ack after 4
         '{32'h002091B3, K_ILL, 4'b0000, 1'b0, 0},  // sll
         '{32'h0080A283, K_ILL, 4'b0000, 1'b0, 0},  // lw
         '{32'h0020A823, K_ILL, 4'b0000, 1'b0, 0},  // sw
         '{32'h00208463, K_ILL, 4'b0000, 1'b0, 0},  // beq
         '{32'h00000000, K_ILL, 4'b0000, 1'b0, 0}   // all zero
      };
      bus.instruction = '0;
      bus.mem_ack = 1'b0;

      for (int i = 0; i < 22; i++) begin
         prog[0] = tbl[i];
         prog[1] = v_zero;
         plen = 2;
         run($sformatf("vec%0d", i), 14, 1'b1);
      end

      prog[0] = tbl[1]; prog[1] = tbl[11]; prog[2] = v_zero; plen = 3;
      run("sub_slti", 16, 1'b1);

      prog[0] = '{32'h0080B283, K_LD, 4'b0010, 1'b1, 2};
      prog[1] = tbl[15]; prog[2] = tbl[7]; prog[3] = v_zero; plen = 4;
      run("ld_sd_addi", 20, 1'b1);

      prog[0] = v_zero; plen = 1;
      run("zero_halt", 24, 1'b1);

      prog[0] = '{32'h0080B283, K_LD, 4'b0010, 1'b1, 0}; plen = 1;
      run("ld_timeout", 24, 1'b1);

      prog[0] = tbl[0]; prog[1] = '{32'h0080B283, K_LD, 4'b0010, 1'b1, 0}; plen = 2;
      run("rst_mid_mem", 10, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      check("mid_mem_memread_before_reset", bus.MemRead, 1);
      check("mid_mem_retired_before_reset", bus.retired, 1);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("mid_mem_memread_after_reset", bus.MemRead, 0);
      check("mid_mem_retired_after_reset", bus.retired, 0);
      check("mid_mem_status_after_reset", {bus.halted, bus.err_code}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
